exec_pipe_sequencer: RTL and testbench

- Run/step/halt controller for the MIPS pipeline.
- Generates the pipeline-enable level that drives the i_debug_enb input of every stage latch: IF/ID, ID/EX, EX/MEM, MEM/WB.
- Takes commands from the debug interface (SPI slave side) and detects program end through the decoded HALT instruction.
- After HALT, drains the pipeline so EX/MEM/WB retire in-flight work before freezing, and keeps an enabled-cycle counter for debug readout.

---
 rtl/exec_pipe_sequencer_pkg.sv | 25 ++
 rtl/exec_pipe_sequencer_sat_counter.sv | 22 ++
 rtl/exec_pipe_sequencer.sv | 134 +++++++++++++
 tb/tb_exec_pipe_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/exec_pipe_sequencer_pkg.sv
// Shared encodings for the pipeline run/step/halt sequencer.
package exec_pipe_sequencer_pkg;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'b00,
    CMD_STEP  = 2'b01,
    CMD_HALT  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int NB_DRAIN_DEF = 3;

  function automatic logic is_enabled_state(input state_t s);
    return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/exec_pipe_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module exec_pipe_sequencer_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/exec_pipe_sequencer.sv
// Run/step/halt controller producing the pipeline-wide stage enable, with
// post-HALT drain and an enabled-cycle counter for debug readout.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | pipeline frozen, waiting for RUN/STEP
// ST_RUN   | free-running until HALT command or HALT opcode in ID
// ST_STEP  | enabled for a fixed number of cycles
// ST_DRAIN | HALT seen in ID; let EX/MEM/WB retire, commands blocked
// ST_DONE  | program ended; only CLEAR leaves
module exec_pipe_sequencer
  import exec_pipe_sequencer_pkg::*;
#(
  parameter int NB_BITS  = 32,
  parameter int NB_STEP  = 16,
  parameter int NB_DRAIN = NB_DRAIN_DEF,
  parameter int NB_CMD   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  input  logic [NB_CMD-1:0]  i_cmd,
  input  logic [NB_STEP-1:0] i_step_count,
  input  logic               i_halt_detect,
  output logic               o_cmd_ready,
  output logic               o_pipe_enb,
  output logic [2:0]         o_state,
  output logic               o_done,
  output logic [NB_BITS-1:0] o_cycle_count
);

  localparam int NB_DCNT = (NB_DRAIN > 2) ? $clog2(NB_DRAIN) : 1;
  localparam logic [NB_DCNT-1:0] DRAIN_LOAD = NB_DCNT'(NB_DRAIN - 1);

  state_t               state, state_nxt;
  logic [NB_STEP-1:0]   step_cnt, step_nxt, step_load;
  logic [NB_DCNT-1:0]   drain_cnt, drain_nxt;
  logic                 pipe_enb, pipe_enb_nxt;
  logic                 cmd_ready, accept, halt_seen, cnt_clr;
  cmd_t                 cmd;

  assign cmd       = cmd_t'(i_cmd);
  assign cmd_ready = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_DONE);
  assign accept    = i_cmd_valid && cmd_ready;
  assign halt_seen = i_halt_detect && pipe_enb;
  // A zero step count still executes one cycle.
  assign step_load = (i_step_count == '0) ? '0 : i_step_count - NB_STEP'(1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= ST_IDLE;
      step_cnt  <= '0;
      drain_cnt <= '0;
      pipe_enb  <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_cnt  <= step_nxt;
      drain_cnt <= drain_nxt;
      pipe_enb  <= pipe_enb_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    drain_nxt = drain_cnt;
    cnt_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_RUN:   state_nxt = ST_RUN;
            CMD_STEP: begin
              state_nxt = ST_STEP;
              step_nxt  = step_load;
            end
            CMD_CLEAR: cnt_clr = 1'b1;
            default:   ;
          endcase
        end
      end
      ST_RUN: begin
        // Opcode detection beats a same-cycle HALT command so in-flight work retires.
        if (halt_seen) begin
          state_nxt = ST_DRAIN;
          drain_nxt = DRAIN_LOAD;
        end else if (accept && (cmd == CMD_HALT)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_seen) begin
          state_nxt = ST_DRAIN;
          drain_nxt = DRAIN_LOAD;
        end else if (step_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          step_nxt = step_cnt - NB_STEP'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = ST_DONE;
        end else begin
          drain_nxt = drain_cnt - NB_DCNT'(1);
        end
      end
      ST_DONE: begin
        if (accept && (cmd == CMD_CLEAR)) begin
          state_nxt = ST_IDLE;
          cnt_clr   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    pipe_enb_nxt = is_enabled_state(state_nxt);
  end

  exec_pipe_sequencer_sat_counter #(
    .WIDTH (NB_BITS)
  ) u_cycle_cnt (
    .clk   (i_clk),
    .rst_n (i_rst),
    .en    (pipe_enb),
    .clr   (cnt_clr),
    .count (o_cycle_count)
  );

  assign o_cmd_ready = cmd_ready;
  assign o_pipe_enb  = pipe_enb;
  assign o_state     = state;
  assign o_done      = (state == ST_DONE);

endmodule

// File: tb/tb_exec_pipe_sequencer.sv
// Directed bench for exec_pipe_sequencer: per-cycle vector table plus
// hand-written reset, timing and saturation sequences.
module tb_exec_pipe_sequencer;

  typedef struct {
    logic        v;
    logic [1:0]  cmd;
    logic [15:0] step;
    logic        hd;
    logic [2:0]  st;
    logic        enb;
    logic        rdy;
    logic        done;
    logic [31:0] cnt;
  } vec_t;

  localparam logic [1:0] RUN = 2'b00, STEP = 2'b01, HALT = 2'b10, CLR = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [15:0] step_count = '0;
  logic        halt_detect = 1'b0;
  logic        cmd_ready, pipe_enb, done;
  logic [2:0]  state;
  logic [31:0] cycle_count;

  logic        cmd_valid2 = 1'b0;
  logic [1:0]  cmd2 = 2'b00;
  logic        cmd_ready2, pipe_enb2, done2;
  logic [2:0]  state2;
  logic [3:0]  cycle_count2;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  exec_pipe_sequencer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cmd_valid   (cmd_valid),
    .i_cmd         (cmd),
    .i_step_count  (step_count),
    .i_halt_detect (halt_detect),
    .o_cmd_ready   (cmd_ready),
    .o_pipe_enb    (pipe_enb),
    .o_state       (state),
    .o_done        (done),
    .o_cycle_count (cycle_count)
  );

  exec_pipe_sequencer #(.NB_BITS(4)) dut4 (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cmd_valid   (cmd_valid2),
    .i_cmd         (cmd2),
    .i_step_count  (16'd0),
    .i_halt_detect (1'b0),
    .o_cmd_ready   (cmd_ready2),
    .o_pipe_enb    (pipe_enb2),
    .o_state       (state2),
    .o_done        (done2),
    .o_cycle_count (cycle_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [1:0] c, input logic [15:0] s, input logic hd,
                     input logic [2:0] st, input logic enb, input logic rdy,
                     input logic dn, input logic [31:0] cnt);
    vec_t r;
    r.v = v; r.cmd = c; r.step = s; r.hd = hd;
    r.st = st; r.enb = enb; r.rdy = rdy; r.done = dn; r.cnt = cnt;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [15:0] s, input logic hd);
    @(negedge clk);
    cmd_valid = v; cmd = c; step_count = s; halt_detect = hd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    cmd_valid = 0; halt_detect = 0; cmd_valid2 = 0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    // inputs held during one cycle -> outputs just after that cycle's edge
    //  v  cmd   step  hd   st   enb rdy done cnt
    add(0, RUN,  0,    0,   0,   0,  1,  0,   0);
    add(1, CLR,  0,    0,   0,   0,  1,  0,   0);
    add(1, RUN,  0,    0,   1,   1,  1,  0,   0);
    add(0, RUN,  0,    0,   1,   1,  1,  0,   1);
    add(1, STEP, 7,    0,   1,   1,  1,  0,   2);
    add(1, CLR,  0,    0,   1,   1,  1,  0,   3);
    add(1, HALT, 0,    0,   0,   0,  1,  0,   4);
    add(0, RUN,  0,    0,   0,   0,  1,  0,   4);
    add(0, RUN,  0,    1,   0,   0,  1,  0,   4);
    add(1, STEP, 2,    0,   2,   1,  0,  0,   4);
    add(0, RUN,  0,    0,   2,   1,  0,  0,   5);
    add(0, RUN,  0,    0,   0,   0,  1,  0,   6);
    add(1, STEP, 0,    0,   2,   1,  0,  0,   6);
    add(1, HALT, 0,    0,   0,   0,  1,  0,   7);
    add(1, CLR,  0,    0,   0,   0,  1,  0,   0);
    add(1, RUN,  0,    0,   1,   1,  1,  0,   0);
    add(1, HALT, 0,    1,   3,   1,  0,  0,   1);
    add(1, CLR,  0,    1,   3,   1,  0,  0,   2);
    add(0, RUN,  0,    0,   3,   1,  0,  0,   3);
    add(0, RUN,  0,    0,   4,   0,  1,  1,   4);
    add(1, RUN,  0,    0,   4,   0,  1,  1,   4);
    add(1, STEP, 3,    0,   4,   0,  1,  1,   4);
    add(1, CLR,  0,    0,   0,   0,  1,  0,   0);
    add(1, STEP, 5,    0,   2,   1,  0,  0,   0);
    add(0, RUN,  0,    0,   2,   1,  0,  0,   1);
    add(0, RUN,  0,    0,   2,   1,  0,  0,   2);
    add(0, RUN,  0,    0,   2,   1,  0,  0,   3);
    add(0, RUN,  0,    0,   2,   1,  0,  0,   4);
    add(0, RUN,  0,    1,   3,   1,  0,  0,   5);
    add(0, RUN,  0,    0,   3,   1,  0,  0,   6);
    add(0, RUN,  0,    0,   3,   1,  0,  0,   7);
    add(0, RUN,  0,    0,   4,   0,  1,  1,   8);
    add(1, CLR,  0,    0,   0,   0,  1,  0,   0);
    add(1, STEP, 4,    0,   2,   1,  0,  0,   0);
    add(0, RUN,  0,    0,   2,   1,  0,  0,   1);
    add(0, RUN,  0,    0,   2,   1,  0,  0,   2);
    add(0, RUN,  0,    0,   2,   1,  0,  0,   3);
    add(0, RUN,  0,    0,   0,   0,  1,  0,   4);

    // reset state, before any clock edge
    #2;
    check("reset state", state, 0);
    check("reset enb", pipe_enb, 0);
    check("reset ready", cmd_ready, 1);
    check("reset done", done, 0);
    check("reset count", cycle_count, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].cmd, vecs[i].step, vecs[i].hd);
      check($sformatf("vec%0d state", i), state, vecs[i].st);
      check($sformatf("vec%0d enb", i), pipe_enb, vecs[i].enb);
      check($sformatf("vec%0d ready", i), cmd_ready, vecs[i].rdy);
      check($sformatf("vec%0d done", i), done, vecs[i].done);
      check($sformatf("vec%0d count", i), cycle_count, vecs[i].cnt);
    end

    // RUN in cycle 5, HALT in cycle 15 -> ten enabled cycles
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      drive(c == 5 || c == 15, (c == 15) ? HALT : RUN, 0, 0);
      if (c == 5)  check("run rise enb", pipe_enb, 1);
      if (c == 10) check("run mid enb", pipe_enb, 1);
      if (c == 15) begin
        check("run halt enb", pipe_enb, 0);
        check("run halt count", cycle_count, 10);
        check("run halt state", state, 0);
      end
    end

    // asynchronous reset between edges in the middle of a STEP
    drive(1, STEP, 10, 0);
    drive(0, RUN, 0, 0);
    drive(0, RUN, 0, 0);
    drive(0, RUN, 0, 0);
    check("pre-reset enb", pipe_enb, 1);
    check("pre-reset count", cycle_count, 13);
    #2;
    rst = 1'b0;
    #1;
    check("async enb", pipe_enb, 0);
    check("async count", cycle_count, 0);
    check("async state", state, 0);
    #1;
    rst = 1'b1;

    // 4-bit counter saturates instead of wrapping
    @(negedge clk);
    cmd_valid2 = 1; cmd2 = RUN;
    @(negedge clk);
    cmd_valid2 = 0;
    repeat (20) @(posedge clk);
    #1;
    check("sat4 state", state2, 1);
    check("sat4 enb", pipe_enb2, 1);
    check("sat4 count", cycle_count2, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
